// File: rtl/pipe_field_if.sv
// Handshake bundle between the game controller and the obstacle-field engine.
// The engine side uses the slave modport; the controller/bench side uses master.
interface pipe_field_if #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8
) ();
  logic                       start;
  logic                       enable;
  logic [ROWS-1:0]            bird_row;
  logic [COLS-1:0][ROWS-1:0]  field;
  logic                       running;
  logic                       crash;
  logic                       score_pulse;

  modport master (
    output start, enable, bird_row,
    input  field, running, crash, score_pulse
  );

  modport slave (
    input  start, enable, bird_row,
    output field, running, crash, score_pulse
  );
endinterface

// File: rtl/pipe_field_engine.sv
// Scrolling pipe-field generator: inserts gapped pipe columns, scrolls at a divided rate,
// detects bird collisions and pulses once per cleared pipe.
module pipe_field_engine #(
  parameter int unsigned ROWS       = 8,
  parameter int unsigned COLS       = 8,
  parameter int unsigned GAP        = 3,
  parameter int unsigned SPACING    = 4,
  parameter int unsigned SCROLL_DIV = 4,
  parameter int unsigned BIRD_COL   = 0,
  parameter logic [7:0]  SEED       = 8'hA5
) (
  input logic         clk,
  input logic         reset,
  pipe_field_if.slave bus
);

  if (GAP == 0 || GAP >= ROWS || SPACING == 0 || SCROLL_DIV == 0 || BIRD_COL >= COLS ||
      SEED == 8'h00) begin : g_param_check
    $error("pipe_field_engine: illegal parameter combination");
  end

  localparam int unsigned DivW  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int unsigned SpW   = (SPACING > 1) ? $clog2(SPACING) : 1;
  localparam int unsigned NGap  = ROWS - GAP + 1;
  localparam logic [ROWS-1:0] GapOnes = ROWS'({GAP{1'b1}});

  typedef enum logic [1:0] {StIdle, StRun, StCrash} state_e;

  state_e                    state_q;
  logic [COLS-1:0][ROWS-1:0] field_q;
  logic [DivW-1:0]           div_q;
  logic [SpW-1:0]            space_q;
  logic [7:0]                lfsr_q;
  logic                      running_q;
  logic                      crash_q;
  logic                      score_q;

  logic            hit;
  logic            div_last;
  logic [7:0]      gap_top;
  logic [ROWS-1:0] pipe_col;
  logic [7:0]      lfsr_next;

  assign hit       = |(field_q[BIRD_COL] & bus.bird_row);
  assign div_last  = (div_q == DivW'(SCROLL_DIV - 1));
  assign gap_top   = lfsr_q % 8'(NGap);
  assign pipe_col  = ~(GapOnes << gap_top);
  assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ 8'hB8) : (lfsr_q >> 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      field_q   <= '0;
      div_q     <= '0;
      space_q   <= '0;
      lfsr_q    <= SEED;
      running_q <= 1'b0;
      crash_q   <= 1'b0;
      score_q   <= 1'b0;
    end else begin
      score_q <= 1'b0;
      unique case (state_q)
        StIdle, StCrash: begin
          // lfsr deliberately keeps its value so successive games differ
          if (bus.start) begin
            state_q   <= StRun;
            field_q   <= '0;
            div_q     <= '0;
            space_q   <= '0;
            running_q <= 1'b1;
            crash_q   <= 1'b0;
          end
        end
        StRun: begin
          if (hit) begin
            state_q   <= StCrash;
            running_q <= 1'b0;
            crash_q   <= 1'b1;
          end else if (bus.enable) begin
            if (div_last) begin
              div_q   <= '0;
              score_q <= |field_q[BIRD_COL];
              for (int c = 0; c < int'(COLS) - 1; c++) begin
                field_q[c] <= field_q[c+1];
              end
              if (space_q == '0) begin
                field_q[COLS-1] <= pipe_col;
                lfsr_q          <= lfsr_next;
                space_q         <= SpW'(SPACING - 1);
              end else begin
                field_q[COLS-1] <= '0;
                space_q         <= space_q - 1'b1;
              end
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.field       = field_q;
  assign bus.running     = running_q;
  assign bus.crash       = crash_q;
  assign bus.score_pulse = score_q;

endmodule

// File: tb/tb_pipe_field_engine.sv
// Bench for pipe_field_engine: per-cycle scoreboard against a behavioural model, driven by a
// phase table with end-of-phase expectations, plus asynchronous reset sequences.
module tb_pipe_field_engine;
  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_field_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  pipe_field_engine #(
    .ROWS(ROWS), .COLS(COLS), .GAP(3), .SPACING(4), .SCROLL_DIV(4), .BIRD_COL(0),
    .SEED(8'hA5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [63:0] field;
    logic        running;
    logic        crash;
    logic        pulse;
  } obs_t;

  typedef struct {
    logic       start;
    logic       enable;
    logic [7:0] bird;
    int         cycles;
    bit         col_en;
    int         col;
    logic [7:0] col_val;
    logic       exp_run;
    logic       exp_crash;
    bit         rst_after;
  } phase_t;

  obs_t   exp_q[$];
  phase_t ph[$];
  int     tests = 0;
  int     fails = 0;

  // Behavioural reference: state 0 idle, 1 run, 2 crash
  int         m_state;
  logic [7:0] m_field [COLS];
  int         m_div;
  int         m_space;
  logic [7:0] m_lfsr;
  logic       m_run, m_crash, m_pulse;

  task automatic model_reset();
    m_state = 0;
    for (int c = 0; c < int'(COLS); c++) m_field[c] = 8'h00;
    m_div = 0; m_space = 0; m_lfsr = 8'hA5;
    m_run = 0; m_crash = 0; m_pulse = 0;
  endtask

  task automatic model_enter_run();
    m_state = 1;
    for (int c = 0; c < int'(COLS); c++) m_field[c] = 8'h00;
    m_div = 0; m_space = 0; m_run = 1; m_crash = 0;
  endtask

  task automatic model_eval(input logic s, input logic e, input logic [7:0] b);
    logic [7:0] ones3;
    logic [7:0] newc;
    int         gap;
    m_pulse = 0;
    if (m_state != 1) begin
      if (s) model_enter_run();
    end else if ((m_field[0] & b) != 8'h00) begin
      m_state = 2; m_run = 0; m_crash = 1;
    end else if (e) begin
      if (m_div < 3) begin
        m_div++;
      end else begin
        m_div = 0;
        m_pulse = (m_field[0] != 8'h00);
        if (m_space == 0) begin
          ones3 = 8'h07;
          gap = int'(m_lfsr) % 6;
          newc = ~(ones3 << gap);
          m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
          m_space = 3;
        end else begin
          newc = 8'h00;
          m_space--;
        end
        for (int c = 0; c < int'(COLS) - 1; c++) m_field[c] = m_field[c+1];
        m_field[COLS-1] = newc;
      end
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    for (int c = 0; c < int'(COLS); c++) o.field[c*8 +: 8] = m_field[c];
    o.running = m_run; o.crash = m_crash; o.pulse = m_pulse;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.field = bus.field; o.running = bus.running; o.crash = bus.crash;
    o.pulse = bus.score_pulse;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got field=%h run=%b crash=%b pulse=%b, expected field=%h run=%b crash=%b pulse=%b",
               name, got.field, got.running, got.crash, got.pulse,
               exp.field, exp.running, exp.crash, exp.pulse);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic check_col(input string name, input int col, input logic [7:0] exp);
    logic [7:0] got;
    got = bus.field[col];
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: field[%0d] got %h, expected %h", name, col, got, exp);
    end
  endtask

  task automatic run_cycle(input logic s, input logic e, input logic [7:0] b);
    @(negedge clk);
    bus.start = s; bus.enable = e; bus.bird_row = b;
    model_eval(s, e, b);
    exp_q.push_back(model_obs());
    @(posedge clk);
    #1;
    check_obs("cycle", dut_obs(), exp_q.pop_front());
  endtask

  // Reset is dropped between clock edges; outputs must clear without waiting for a clock.
  task automatic async_reset_check();
    @(negedge clk);
    #1;
    reset = 1'b0;
    bus.start = 1'b0;
    model_reset();
    #1;
    check_obs("async_reset", dut_obs(), '0);
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic phase_t mk(input logic s, input logic e, input logic [7:0] b, input int n,
                                input bit ce, input int col, input logic [7:0] cv,
                                input logic er, input logic ec, input bit ra);
    phase_t p;
    p.start = s; p.enable = e; p.bird = b; p.cycles = n; p.col_en = ce; p.col = col;
    p.col_val = cv; p.exp_run = er; p.exp_crash = ec; p.rst_after = ra;
    return p;
  endfunction

  initial begin
    ph.push_back(mk(0, 0, 8'h00, 20, 1, 7, 8'h00, 0, 0, 0)); // idle after reset
    ph.push_back(mk(1, 1, 8'h00,  1, 1, 7, 8'h00, 1, 0, 0)); // start
    ph.push_back(mk(0, 1, 8'h00,  4, 1, 7, 8'hC7, 1, 0, 0)); // first step, gap_top 3
    ph.push_back(mk(0, 1, 8'h00,  4, 1, 6, 8'hC7, 1, 0, 0));
    ph.push_back(mk(0, 1, 8'h00, 12, 1, 7, 8'hF8, 1, 0, 0)); // second pipe from lfsr EA
    ph.push_back(mk(0, 1, 8'h08, 12, 1, 0, 8'hC7, 1, 0, 0)); // pipe at bird column
    ph.push_back(mk(0, 1, 8'h08,  4, 1, 0, 8'h00, 1, 0, 0)); // cleared: score pulse
    ph.push_back(mk(0, 1, 8'h08, 20, 1, 0, 8'hF8, 0, 1, 0)); // second pipe hits
    ph.push_back(mk(0, 1, 8'h08, 50, 1, 0, 8'hF8, 0, 1, 1)); // frozen, then reset in CRASH
    ph.push_back(mk(1, 1, 8'h01,  1, 1, 7, 8'h00, 1, 0, 0));
    ph.push_back(mk(0, 1, 8'h01,  4, 1, 7, 8'hC7, 1, 0, 0)); // lfsr back at A5
    ph.push_back(mk(0, 1, 8'h01, 28, 1, 0, 8'hC7, 1, 0, 0));
    ph.push_back(mk(0, 1, 8'h01,  1, 1, 0, 8'hC7, 0, 1, 0)); // crash next cycle
    ph.push_back(mk(0, 1, 8'h01, 10, 1, 0, 8'hC7, 0, 1, 0));
    ph.push_back(mk(1, 1, 8'h00,  1, 1, 0, 8'h00, 1, 0, 0)); // restart clears field
    ph.push_back(mk(0, 1, 8'h00,  6, 0, 0, 8'h00, 1, 0, 0));
    ph.push_back(mk(0, 0, 8'h00, 10, 0, 0, 8'h00, 1, 0, 0)); // paused
    ph.push_back(mk(0, 1, 8'h00, 26, 0, 0, 8'h00, 1, 0, 0));
    ph.push_back(mk(0, 0, 8'hFF,  3, 0, 0, 8'h00, 0, 1, 0)); // hit while paused
    ph.push_back(mk(1, 1, 8'h00,  1, 0, 0, 8'h00, 1, 0, 0));
    ph.push_back(mk(0, 1, 8'h00,  6, 0, 0, 8'h00, 1, 0, 1)); // reset mid-run
    ph.push_back(mk(1, 1, 8'h00,  1, 0, 0, 8'h00, 1, 0, 0));
    ph.push_back(mk(0, 1, 8'h00,  4, 1, 7, 8'hC7, 1, 0, 0));

    reset = 1'b0;
    bus.start = 1'b0; bus.enable = 1'b0; bus.bird_row = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_obs("reset_state", dut_obs(), '0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < ph.size(); i++) begin
      for (int n = 0; n < ph[i].cycles; n++) begin
        run_cycle(n == 0 ? ph[i].start : 1'b0, ph[i].enable, ph[i].bird);
      end
      check_bit($sformatf("phase%0d_running", i), bus.running, ph[i].exp_run);
      check_bit($sformatf("phase%0d_crash", i), bus.crash, ph[i].exp_crash);
      if (ph[i].col_en) check_col($sformatf("phase%0d_col", i), ph[i].col, ph[i].col_val);
      if (ph[i].rst_after) async_reset_check();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
